// File: rtl/aec_char_feeder.sv
// Character FIFO in front of the AEC: buffers host bytes and replays each complete
// '='-terminated expression as a gap-free burst. Optional input filter: FEEDER_FILTER_EN.
module aec_char_feeder #(
    parameter int         DEPTH     = 32,
    parameter logic [7:0] IDLE_CHAR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] ascii_in,
    output logic       ready,
    input  logic       aec_valid,
    output logic       busy,
    output logic [7:0] expr_cnt
`ifdef FEEDER_FILTER_EN
   ,output logic [7:0] drop_cnt
`endif
);
    // state | meaning
    // IDLE  | no burst; starts one when a complete expression is buffered
    // SEND  | one byte per cycle to the AEC until '=' has been presented
    // WAIT  | expression sent, waiting for the AEC result pulse
    localparam int         AW = $clog2(DEPTH);
    localparam int         CW = $clog2(DEPTH + 1);
    localparam logic [7:0] EQ = 8'h3D;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, eq_cnt;
    logic            full, empty, keep, accept, push, pop, push_eq, pop_eq;
    logic [7:0]      head, ascii_nxt;
    logic            ready_nxt, expr_inc;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign head     = mem[rd_ptr];
    assign busy     = (state != S_IDLE);

`ifdef FEEDER_FILTER_EN
    function automatic logic is_expr_char(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66) ||
               (c inside {8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2D, EQ});
    endfunction
    assign keep = is_expr_char(in_data);
`else
    assign keep = 1'b1;
`endif

    assign accept  = in_valid && in_ready;
    assign push    = accept && keep;
    assign push_eq = push && (in_data == EQ);
    assign pop_eq  = pop && (head == EQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (eq_cnt != '0)     state_nxt = S_SEND;
            S_SEND: if (ascii_in == EQ)   state_nxt = S_WAIT;
            S_WAIT: if (aec_valid)        state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        ascii_nxt = IDLE_CHAR;
        ready_nxt = 1'b0;
        expr_inc  = 1'b0;
        case (state)
            S_IDLE: if (eq_cnt != '0) begin
                pop       = 1'b1;
                ascii_nxt = head;
                ready_nxt = 1'b1;
            end
            S_SEND: begin
                if (ascii_in == EQ) begin
                    expr_inc = 1'b1;
                end else if (!empty) begin
                    pop       = 1'b1;
                    ascii_nxt = head;
                end
            end
            default: ;
        endcase
    end

    // Storage has no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            eq_cnt   <= '0;
            ascii_in <= IDLE_CHAR;
            ready    <= 1'b0;
            expr_cnt <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            case ({push_eq, pop_eq})
                2'b10:   eq_cnt <= eq_cnt + CW'(1);
                2'b01:   eq_cnt <= eq_cnt - CW'(1);
                default: ;
            endcase
            ascii_in <= ascii_nxt;
            ready    <= ready_nxt;
            if (expr_inc) expr_cnt <= expr_cnt + 8'd1;
        end
    end

`ifdef FEEDER_FILTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        drop_cnt <= 8'd0;
        else if (accept && !keep && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_aec_char_feeder.sv
// Self-checking bench for aec_char_feeder: queue-based reference model checked every
// cycle, plus directed literal checks on burst contents, latency and counters.
module tb_aec_char_feeder;
    localparam int         DEPTH = 32;
    localparam logic [7:0] IDLE  = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic [7:0] ascii_in;
    logic       ready;
    logic       aec_valid = 1'b0;
    logic       busy;
    logic [7:0] expr_cnt;
`ifdef FEEDER_FILTER_EN
    logic [7:0] drop_cnt;
`endif

    aec_char_feeder #(.DEPTH(DEPTH), .IDLE_CHAR(IDLE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ascii_in(ascii_in), .ready(ready),
        .aec_valid(aec_valid), .busy(busy), .expr_cnt(expr_cnt)
`ifdef FEEDER_FILTER_EN
       ,.drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    int         m_phase = 0;  // 0 idle, 1 sending, 2 waiting for result
    logic [7:0] m_ascii = IDLE;
    logic       m_ready = 1'b0;
    int         m_expr  = 0;
    int         m_drop  = 0;

    function automatic bit model_keeps(input logic [7:0] c);
`ifdef FEEDER_FILTER_EN
        string allowed = "0123456789abcdef()*+-=";
        for (int i = 0; i < allowed.len(); i++)
            if (allowed[i] == c) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_phase = 0; m_ascii = IDLE; m_ready = 1'b0; m_expr = 0; m_drop = 0;
            end else begin
                bit full_before, has_eq;
                full_before = (mq.size() >= DEPTH);
                has_eq = 1'b0;
                foreach (mq[i]) if (mq[i] == 8'h3D) has_eq = 1'b1;
                m_ready = 1'b0;
                if (m_phase == 0) begin
                    m_ascii = IDLE;
                    if (has_eq) begin
                        m_ascii = mq.pop_front();
                        m_ready = 1'b1;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (m_ascii == 8'h3D) begin
                        m_ascii = IDLE;
                        m_expr  = (m_expr + 1) % 256;
                        m_phase = 2;
                    end else begin
                        m_ascii = mq.pop_front();
                    end
                end else if (aec_valid) begin
                    m_phase = 0;
                end
                if (in_valid && !full_before) begin
                    if (model_keeps(in_data)) mq.push_back(in_data);
                    else if (m_drop < 255)    m_drop++;
                end
            end
        end
    end

    // ---------------- per-cycle compare and burst capture ----------------
    int         cyc = 0;
    int         ready_cyc = 0;
    int         n_bursts = 0;
    bit         collecting = 1'b0;
    logic [7:0] cur_burst[$];
    logic [7:0] last_burst[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            collecting = 1'b0;
        end else begin
            chk("ascii_in", ascii_in, m_ascii);
            chk("ready",    ready,    m_ready);
            chk("busy",     busy,     m_phase != 0);
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("expr_cnt", expr_cnt, m_expr[7:0]);
`ifdef FEEDER_FILTER_EN
            chk("drop_cnt", drop_cnt, m_drop[7:0]);
`endif
            if (ready) begin
                collecting = 1'b1;
                cur_burst.delete();
                ready_cyc = cyc;
            end
            if (collecting) begin
                cur_burst.push_back(ascii_in);
                if (ascii_in == 8'h3D) begin
                    collecting = 1'b0;
                    last_burst = cur_burst;
                    n_bursts++;
                end
            end
        end
    end

    task automatic chk_burst(input string name, input string exp);
        bit ok;
        ok = (last_burst.size() == exp.len());
        if (ok) for (int i = 0; i < exp.len(); i++) if (last_burst[i] != exp[i]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got burst of %0d bytes, expected \"%s\" (%0d bytes)",
                     name, last_burst.size(), exp, exp.len());
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int aec_cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_expr(input string name);
        int t = 0;
        while (m_phase != 2 && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk({name, "_wait_timeout"}, 1, 0);
        aec_valid = 1'b1;
        aec_cyc   = cyc;
        step();
        aec_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, t;
        rst = 1'b1;
        #1;
        chk("rst_ascii",    ascii_in, IDLE);
        chk("rst_ready",    ready,    0);
        chk("rst_busy",     busy,     0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_expr_cnt", expr_cnt, 0);
        wait_cycles(2);
        rst = 1'b0;
        step();

        // single expression
        push_str("3+4=");
        wait_cycles(8);
        chk_burst("burst_3p4", "3+4=");
        chk("t1_busy_waiting", busy, 1);
        chk("t1_ascii_idle",   ascii_in, 8'h00);
        finish_expr("t1");
        wait_cycles(1);
        chk("t1_busy_after_valid", busy, 0);
        chk("t1_expr_cnt", expr_cnt, 1);

        // two expressions back to back; second held until aec_valid
        nb = n_bursts;
        push_str("2*(a-1)=f=");
        wait_cycles(20);
        chk("t2_one_burst", n_bursts, nb + 1);
        chk_burst("burst_long", "2*(a-1)=");
        chk("t2_held_busy", busy, 1);
        finish_expr("t2a");
        wait_cycles(8);
        chk("t2_two_bursts", n_bursts, nb + 2);
        chk_burst("burst_f", "f=");
        chk("t2_restart_latency", ready_cyc - aec_cyc, 2);
        finish_expr("t2b");
        wait_cycles(2);
        chk("t2_expr_cnt", expr_cnt, 3);

        // incomplete expression is not sent
        nb = n_bursts;
        push_str("1+2+3");
        wait_cycles(10);
        chk("t3_no_burst", n_bursts, nb);
        chk("t3_ascii_idle", ascii_in, 8'h00);
        chk("t3_no_ready", ready, 0);
        push_str("=");
        wait_cycles(10);
        chk_burst("burst_6", "1+2+3=");
        finish_expr("t3");
        wait_cycles(2);
        chk("t3_expr_cnt", expr_cnt, 4);

        // fill FIFO; 33rd byte refused
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_in_ready_filling", in_ready, 1);
            push_str("1");
        end
        chk("t4_full_in_ready", in_ready, 0);
        push_str("=");
        wait_cycles(5);
        chk("t4_refused_no_burst", busy, 0);
        chk("t4_still_full", in_ready, 0);
        do_reset();
        chk("t4_after_reset_in_ready", in_ready, 1);

        // reset in the middle of a burst
        push_str("9+9=");
        t = 0;
        while (!ready && t < 20) begin
            step();
            t++;
        end
        chk("t5_burst_started", ready, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ascii",    ascii_in, 8'h00);
        chk("t5_rst_ready",    ready,    0);
        chk("t5_rst_busy",     busy,     0);
        chk("t5_rst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        step();
        push_str("5=");
        wait_cycles(6);
        chk_burst("burst_after_rst", "5=");
        finish_expr("t5");
        wait_cycles(2);
        chk("t5_expr_cnt", expr_cnt, 1);

`ifdef FEEDER_FILTER_EN
        push_str("1 + 2=");
        wait_cycles(10);
        chk_burst("burst_filtered", "1+2=");
        chk("t6_drop_cnt", drop_cnt, 2);
        finish_expr("t6");
        wait_cycles(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
